// File: rtl/demux1x4_reg_if.sv
// demux1x4_reg_if
//   Bundles the producer-side request signals and the four registered lane
//   outputs of demux1x4_reg into one interface.
//   Parameters: WIDTH (lane data width), CNT_W (transfer counter width).
//   Modports:
//     master - producer/monitor side: drives en, in_valid, sel, i, cnt_clr;
//              observes y0..y3, y_valid, cnt0..cnt3.
//     slave  - demultiplexer side: the mirror image of master.
interface demux1x4_reg_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic             in_valid;
  logic [1:0]       sel;
  logic [WIDTH-1:0] i;
  logic             cnt_clr;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [3:0]       y_valid;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;

  modport master (
    output en, in_valid, sel, i, cnt_clr,
    input  y0, y1, y2, y3, y_valid, cnt0, cnt1, cnt2, cnt3
  );

  modport slave (
    input  en, in_valid, sel, i, cnt_clr,
    output y0, y1, y2, y3, y_valid, cnt0, cnt1, cnt2, cnt3
  );
endinterface

// File: rtl/demux1x4_reg.sv
// demux1x4_reg
//   Registered 1-to-4 demultiplexer. A transfer on `i` is steered to the lane
//   chosen by `sel` one clock later; unselected lanes read zero and are
//   qualified off by a one-hot y_valid strobe. Each lane keeps a saturating
//   transfer counter for monitoring.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - demux1x4_reg_if.slave: en, in_valid, sel, i, cnt_clr in;
//            y0..y3, y_valid, cnt0..cnt3 out (all registered)
module demux1x4_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  demux1x4_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] y_r       [4];
  logic [3:0]       y_valid_r;
  logic [CNT_W-1:0] cnt_r     [4];

  logic [WIDTH-1:0] y_nxt_s       [4];
  logic [3:0]       y_valid_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s     [4];

  // Lane data / strobe decode: only the selected lane carries data, and
  // only when the producer marks the cycle as a transfer.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      y_nxt_s[k] = {WIDTH{1'b0}};
    end
    y_valid_nxt_s = 4'b0000;
    if (bus.in_valid) begin
      case (bus.sel)
        2'b00: begin
          y_nxt_s[0]    = bus.i;
          y_valid_nxt_s = 4'b0001;
        end
        2'b01: begin
          y_nxt_s[1]    = bus.i;
          y_valid_nxt_s = 4'b0010;
        end
        2'b10: begin
          y_nxt_s[2]    = bus.i;
          y_valid_nxt_s = 4'b0100;
        end
        2'b11: begin
          y_nxt_s[3]    = bus.i;
          y_valid_nxt_s = 4'b1000;
        end
        default: begin
          y_valid_nxt_s = 4'b0000;
        end
      endcase
    end else begin
      y_valid_nxt_s = 4'b0000;
    end
  end

  // Counter update: clear wins over a same-cycle increment; increments
  // stop at all-ones instead of wrapping.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_nxt_s[k] = cnt_r[k];
    end
    if (bus.cnt_clr) begin
      for (int k = 0; k < 4; k++) begin
        cnt_nxt_s[k] = {CNT_W{1'b0}};
      end
    end else if (bus.in_valid) begin
      if (cnt_r[bus.sel] != CNT_MAX) begin
        cnt_nxt_s[bus.sel] = cnt_r[bus.sel] + CNT_ONE;
      end else begin
        cnt_nxt_s[bus.sel] = CNT_MAX;
      end
    end else begin
      cnt_nxt_s[0] = cnt_r[0];
    end
  end

  // State registers: everything, counters included, holds while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        y_r[k]   <= {WIDTH{1'b0}};
        cnt_r[k] <= {CNT_W{1'b0}};
      end
      y_valid_r <= 4'b0000;
    end else if (bus.en) begin
      for (int k = 0; k < 4; k++) begin
        y_r[k]   <= y_nxt_s[k];
        cnt_r[k] <= cnt_nxt_s[k];
      end
      y_valid_r <= y_valid_nxt_s;
    end
  end

  assign bus.y0      = y_r[0];
  assign bus.y1      = y_r[1];
  assign bus.y2      = y_r[2];
  assign bus.y3      = y_r[3];
  assign bus.y_valid = y_valid_r;
  assign bus.cnt0    = cnt_r[0];
  assign bus.cnt1    = cnt_r[1];
  assign bus.cnt2    = cnt_r[2];
  assign bus.cnt3    = cnt_r[3];

endmodule

// File: tb/tb_demux1x4_reg.sv
// tb_demux1x4_reg
//   Self-checking bench for demux1x4_reg (WIDTH=8, CNT_W=2 so that counter
//   saturation is reachable quickly). A reference model computes the
//   expected registered state for every driven cycle and pushes it to a
//   scoreboard queue; each test task pops and compares after the edge.
module tb_demux1x4_reg;

  localparam int W = 8;
  localparam int C = 2;

  typedef struct packed {
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic [3:0]   v;
    logic [C-1:0] c0;
    logic [C-1:0] c1;
    logic [C-1:0] c2;
    logic [C-1:0] c3;
  } obs_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  obs_t mdl;
  obs_t exp_o;
  obs_t got_o;
  obs_t sb[$];

  demux1x4_reg_if #(.WIDTH(W), .CNT_W(C)) bus ();

  demux1x4_reg #(.WIDTH(W), .CNT_W(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.y0 = bus.y0;  o.y1 = bus.y1;  o.y2 = bus.y2;  o.y3 = bus.y3;
    o.v  = bus.y_valid;
    o.c0 = bus.cnt0; o.c1 = bus.cnt1; o.c2 = bus.cnt2; o.c3 = bus.cnt3;
    return o;
  endfunction

  // Independent reference model of one clock edge.
  function automatic obs_t model_step(obs_t cur, logic e, logic iv,
                                      logic [1:0] s, logic [W-1:0] d, logic c);
    obs_t n;
    logic [C-1:0] cnt [4];
    n = cur;
    if (!e) return n;
    n.y0 = '0; n.y1 = '0; n.y2 = '0; n.y3 = '0; n.v = 4'b0000;
    if (iv) begin
      n.v = 4'b0001 << s;
      if (s == 2'd0) n.y0 = d;
      if (s == 2'd1) n.y1 = d;
      if (s == 2'd2) n.y2 = d;
      if (s == 2'd3) n.y3 = d;
    end
    cnt[0] = cur.c0; cnt[1] = cur.c1; cnt[2] = cur.c2; cnt[3] = cur.c3;
    if (c) begin
      for (int k = 0; k < 4; k++) cnt[k] = '0;
    end else if (iv && (cnt[s] != 2'd3)) begin
      cnt[s] = cnt[s] + 2'd1;
    end
    n.c0 = cnt[0]; n.c1 = cnt[1]; n.c2 = cnt[2]; n.c3 = cnt[3];
    return n;
  endfunction

  // Drive one cycle of stimulus, record its expectation, and clock it in.
  task automatic drive(input logic e, input logic iv, input logic [1:0] s,
                       input logic [W-1:0] d, input logic c);
    bus.en = e; bus.in_valid = iv; bus.sel = s; bus.i = d; bus.cnt_clr = c;
    mdl = model_step(mdl, e, iv, s, d, c);
    sb.push_back(mdl);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.sel = 2'b00; bus.i = '0; bus.cnt_clr = 1'b0;
    mdl = '0;
    repeat (2) @(posedge clk);
    #1;
    got_o = sample();
    total_cnt++;
    if (got_o !== obs_t'(0)) $display("FAIL reset_state got=%h exp=%h", got_o, obs_t'(0));
    else pass_cnt++;
    rst = 1'b0;
    // Disabled edge after release: outputs must still read zero.
    drive(1'b0, 1'b1, 2'b10, 8'hFF, 1'b0);
    exp_o = sb.pop_front(); got_o = sample();
    total_cnt++;
    if (got_o !== exp_o) $display("FAIL reset_hold got=%h exp=%h", got_o, exp_o);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 2; d++) begin
        drive(1'b1, 1'b1, 2'(s), W'(d), 1'b0);
        exp_o = sb.pop_front(); got_o = sample();
        total_cnt++;
        if (got_o !== exp_o) $display("FAIL sweep sel=%0d i=%0d got=%h exp=%h", s, d, got_o, exp_o);
        else pass_cnt++;
      end
    end
    // Spot check against a hand-written constant: sel=10, i=1.
    drive(1'b1, 1'b1, 2'b10, 8'h01, 1'b0);
    exp_o = sb.pop_front(); got_o = sample();
    total_cnt++;
    if (got_o.y2 !== 8'h01 || got_o.v !== 4'b0100 || got_o.y0 !== 8'h00 ||
        got_o.y1 !== 8'h00 || got_o.y3 !== 8'h00)
      $display("FAIL sweep_sel2 got=%h exp y2=01 v=0100", got_o);
    else pass_cnt++;
  endtask

  task automatic test_gating();
    // en=0: everything frozen, cnt_clr ignored.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 2'(k), 8'($urandom_range(255)), k[0]);
      exp_o = sb.pop_front(); got_o = sample();
      total_cnt++;
      if (got_o !== exp_o) $display("FAIL gate_en0 step=%0d got=%h exp=%h", k, got_o, exp_o);
      else pass_cnt++;
    end
    // en=1, in_valid=0: lanes and strobes cleared, counters unchanged.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 2'(k + 1), 8'hFF, 1'b0);
      exp_o = sb.pop_front(); got_o = sample();
      total_cnt++;
      if (got_o !== exp_o || got_o.v !== 4'b0000)
        $display("FAIL gate_nv step=%0d got=%h exp=%h", k, got_o, exp_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels [4];
    logic [3:0] vexp [4];
    sels[0] = 2'b00; sels[1] = 2'b01; sels[2] = 2'b11; sels[3] = 2'b10;
    vexp[0] = 4'b0001; vexp[1] = 4'b0010; vexp[2] = 4'b1000; vexp[3] = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, sels[k], 8'h01, 1'b0);
      exp_o = sb.pop_front(); got_o = sample();
      total_cnt++;
      if (got_o !== exp_o || got_o.v !== vexp[k])
        $display("FAIL b2b step=%0d got=%h exp=%h", k, got_o, exp_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    logic [C-1:0] c1tbl [5];
    c1tbl[0] = 2'd1; c1tbl[1] = 2'd2; c1tbl[2] = 2'd3; c1tbl[3] = 2'd3; c1tbl[4] = 2'd3;
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b1);
    exp_o = sb.pop_front(); got_o = sample();
    total_cnt++;
    if (got_o !== exp_o) $display("FAIL clr_idle got=%h exp=%h", got_o, exp_o);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 2'b01, 8'h5A, 1'b0);
      exp_o = sb.pop_front(); got_o = sample();
      total_cnt++;
      if (got_o !== exp_o || got_o.c1 !== c1tbl[k] ||
          got_o.c0 !== 2'd0 || got_o.c2 !== 2'd0 || got_o.c3 !== 2'd0)
        $display("FAIL sat step=%0d cnt1=%0d exp_cnt1=%0d got=%h exp=%h",
                 k, got_o.c1, c1tbl[k], got_o, exp_o);
      else pass_cnt++;
    end
    // Clear together with a transfer: transfer lands, but is not counted.
    drive(1'b1, 1'b1, 2'b01, 8'h3C, 1'b1);
    exp_o = sb.pop_front(); got_o = sample();
    total_cnt++;
    if (got_o !== exp_o || {got_o.c0, got_o.c1, got_o.c2, got_o.c3} !== 8'h00)
      $display("FAIL clr_xfer got=%h exp=%h", got_o, exp_o);
    else pass_cnt++;
  endtask

  task automatic test_wide();
    drive(1'b1, 1'b1, 2'b11, 8'hA5, 1'b0);
    exp_o = sb.pop_front(); got_o = sample();
    total_cnt++;
    if (got_o !== exp_o || got_o.y3 !== 8'hA5 || got_o.v !== 4'b1000)
      $display("FAIL wide got=%h exp=%h", got_o, exp_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 2'b10, 8'h01, 1'b0);
    exp_o = sb.pop_front(); got_o = sample();
    total_cnt++;
    if (got_o !== exp_o || got_o.y2 !== 8'h01 || got_o.v !== 4'b0100)
      $display("FAIL pre_rst got=%h exp=%h", got_o, exp_o);
    else pass_cnt++;
    // Assert reset between edges; outputs must clear without a clock.
    bus.in_valid = 1'b1; bus.sel = 2'b00; bus.i = 8'hFF;
    #2 rst = 1'b1;
    #1;
    got_o = sample();
    total_cnt++;
    if (got_o !== obs_t'(0)) $display("FAIL async_rst got=%h exp=%h", got_o, obs_t'(0));
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl = '0;
    drive(1'b1, 1'b1, 2'b00, 8'h7E, 1'b0);
    exp_o = sb.pop_front(); got_o = sample();
    total_cnt++;
    if (got_o !== exp_o) $display("FAIL post_rst got=%h exp=%h", got_o, exp_o);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_sweep();
    test_gating();
    test_back_to_back();
    test_saturation();
    test_wide();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
